// File: rtl/mem_pkg.sv
// Shared definitions for controllers that sit in front of a mem_mod memory.
// Holds the output-stage state encodings so future memory-side blocks
// can reuse the same codes.
package mem_pkg;

  localparam logic [1:0] S_EMPTY_CODE = 2'd0;
  localparam logic [1:0] S_FETCH_CODE = 2'd1;
  localparam logic [1:0] S_FULL_CODE  = 2'd2;

  typedef enum logic [1:0] {
    S_EMPTY = S_EMPTY_CODE,
    S_FETCH = S_FETCH_CODE,
    S_FULL  = S_FULL_CODE
  } out_state_t;

endpackage

// File: rtl/mem_mod.sv
// Simple single-cycle-latency memory used behind fifo_ctrl.
// A read returns data in the following cycle; a write issued in the same
// cycle as a read is dropped, which is why the controller never overlaps them.
module mem_mod #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_ADDR   = 4,
  parameter int ADDR_W     = $clog2(MAX_ADDR)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [MAX_ADDR];

  // Read wins the cycle; contents are never cleared.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/wrap_ptr.sv
// Address pointer that advances by one on inc and wraps from DEPTH-1 to 0.
// DEPTH need not be a power of two, so the wrap is an explicit compare.
module wrap_ptr #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     inc,
  output logic [$clog2(DEPTH)-1:0] ptr
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  // Advance on inc, returning to zero after the last memory address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + PW'(1);
    end
  end

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller wrapping an external single-port-style memory (mem_mod).
// Entries live in memory until fetched into a one-entry registered output
// stage. Reads take priority over writes; the fetch cycle never reads, so
// the producer always gets a write slot at least every other cycle.
module fifo_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         mem_wr_en,
  output logic [ADDR_W-1:0]            mem_wr_addr,
  output logic [DATA_WIDTH-1:0]        mem_wr_data,
  output logic                         mem_rd_en,
  output logic [ADDR_W-1:0]            mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]        mem_rd_data,
  output logic [$clog2(DEPTH+2)-1:0]   count
);

  localparam int CNT_W  = $clog2(DEPTH + 2);
  localparam int MCNT_W = $clog2(DEPTH + 1);
  localparam int PW     = $clog2(DEPTH);

  out_state_t          state;
  logic [MCNT_W-1:0]   mem_cnt;
  logic                mem_has_data;
  logic                mem_has_room;
  logic                stage_busy;
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;

  assign mem_has_data = (mem_cnt != '0);
  assign mem_has_room = (mem_cnt < MCNT_W'(DEPTH));
  assign stage_busy   = (state != S_EMPTY);

  // Fetch whenever the output stage is or is about to become free.
  assign mem_rd_en   = ((state == S_EMPTY) || ((state == S_FULL) && out_ready)) && mem_has_data;
  assign in_ready    = mem_has_room && !mem_rd_en;
  assign mem_wr_en   = in_valid && in_ready;
  assign mem_wr_data = in_data;
  assign mem_wr_addr = ADDR_W'(wr_ptr);
  assign mem_rd_addr = ADDR_W'(rd_ptr);

  assign count = CNT_W'(mem_cnt) + {{(CNT_W-1){1'b0}}, stage_busy};

  wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (mem_wr_en),
    .ptr   (wr_ptr)
  );

  wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (mem_rd_en),
    .ptr   (rd_ptr)
  );

  // Track how many entries are held in memory (writes and reads never overlap).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_cnt <= '0;
    end else if (mem_wr_en) begin
      mem_cnt <= mem_cnt + MCNT_W'(1);
    end else if (mem_rd_en) begin
      mem_cnt <= mem_cnt - MCNT_W'(1);
    end
  end

  // Output-stage FSM: empty -> fetch (read in flight) -> full, holding while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        S_EMPTY: begin
          if (mem_has_data) begin
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          out_data  <= mem_rd_data;
          out_valid <= 1'b1;
          state     <= S_FULL;
        end
        S_FULL: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= mem_has_data ? S_FETCH : S_EMPTY;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= S_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl with mem_mod attached (DEPTH=4, DATA_WIDTH=8).
// The reference is a plain queue of accepted-but-undelivered entries.
module tb_fifo_ctrl;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int CW    = 3;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data;
  logic [CW-1:0] count;

  int total = 0;
  int bad   = 0;

  fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_W(AW)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .count       (count)
  );

  mem_mod #(.DATA_WIDTH(DW), .MAX_ADDR(DEPTH), .ADDR_W(AW)) u_mem (
    .clk     (clk),
    .wr_en   (mem_wr_en),
    .wr_addr (mem_wr_addr),
    .wr_data (mem_wr_data),
    .rd_en   (mem_rd_en),
    .rd_addr (mem_rd_addr),
    .rd_data (mem_rd_data)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    // reset values while held in reset from time zero
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #2;
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_in_ready: got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_out_valid: got=%b want=0", out_valid); end
    total++; if (count !== 3'd0) begin bad++; $display("[TB] FAIL rst_count: got=%0d want=0", count); end
    total++; if (out_data !== 8'h00) begin bad++; $display("[TB] FAIL rst_out_data: got=%h want=00", out_data); end
    total++; if (mem_rd_en !== 1'b0 || mem_wr_en !== 1'b0) begin bad++; $display("[TB] FAIL rst_mem_en: got=%b%b want=00", mem_rd_en, mem_wr_en); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    // write one entry, let its read go in flight, then reset mid-read
    in_valid = 1'b1; in_data = 8'hA5;
    @(posedge clk); #1 in_valid = 1'b0;
    total++; if (mem_rd_en !== 1'b1) begin bad++; $display("[TB] FAIL midrd_issue: got=%b want=1", mem_rd_en); end
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin bad++; $display("[TB] FAIL midrd_out: got=%b/%h want=0/00", out_valid, out_data); end
    total++; if (count !== 3'd0) begin bad++; $display("[TB] FAIL midrd_count: got=%0d want=0", count); end
    total++; if (mem_rd_en !== 1'b0 || mem_wr_en !== 1'b0) begin bad++; $display("[TB] FAIL midrd_mem_en: got=%b%b want=00", mem_rd_en, mem_wr_en); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL midrd_in_ready: got=%b want=1", in_ready); end
    @(posedge clk); #1 rst_n = 1'b1;
    // the discarded read must never surface
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1) begin
        bad++; $display("[TB] FAIL post_rst: got=v%b c%0d r%b want=v0 c0 r1", out_valid, count, in_ready);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fill();
    int idx = 0;
    int cyc = 0;
    out_ready = 1'b0;
    while (idx < 5 && cyc < 20) begin
      in_valid = 1'b1;
      in_data  = DW'((idx + 1) * 17);
      @(negedge clk);
      if (in_ready) begin
        total++; if (mem_wr_en !== 1'b1 || mem_wr_addr !== AW'(idx % 4)) begin
          bad++; $display("[TB] FAIL fill_addr: got=en%b a%0d want=en1 a%0d", mem_wr_en, mem_wr_addr, idx % 4);
        end
        idx++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    total++; if (idx != 5) begin bad++; $display("[TB] FAIL fill_timeout: got=%0d want=5", idx); end
    in_valid = 1'b1; in_data = 8'h66;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (in_ready !== 1'b0 || mem_wr_en !== 1'b0) begin bad++; $display("[TB] FAIL fill_stall: got=r%b w%b want=r0 w0", in_ready, mem_wr_en); end
      total++; if (count !== 3'd5) begin bad++; $display("[TB] FAIL fill_count: got=%0d want=5", count); end
      total++; if (out_valid !== 1'b1 || out_data !== 8'h11) begin bad++; $display("[TB] FAIL fill_head: got=%b/%h want=1/11", out_valid, out_data); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_drain();
    int k = 0;
    int last = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int cyc = 0; cyc < 40 && k < 5; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        total++; if (out_data !== DW'((k + 1) * 17)) begin bad++; $display("[TB] FAIL drain_data: got=%h want=%h", out_data, DW'((k + 1) * 17)); end
        if (k > 0) begin
          total++; if (cyc - last != 2) begin bad++; $display("[TB] FAIL drain_rate: got=%0d want=2", cyc - last); end
        end
        last = cyc;
        k++;
      end
      @(posedge clk); #1;
    end
    total++; if (k != 5) begin bad++; $display("[TB] FAIL drain_timeout: got=%0d want=5", k); end
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || count !== 3'd0) begin bad++; $display("[TB] FAIL drain_end: got=v%b c%0d want=v0 c0", out_valid, count); end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    logic [DW-1:0] items [12];
    int src = 0, wrn = 0, rdn = 0, outn = 0;
    for (int i = 0; i < 12; i++) items[i] = DW'($urandom);
    do_reset();
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 300 && outn < 12; cyc++) begin
      in_valid = (src < 12);
      in_data  = items[src % 12];
      @(negedge clk);
      if (mem_wr_en) begin
        total++; if (mem_wr_addr !== AW'(wrn % 4)) begin bad++; $display("[TB] FAIL wrap_wr_addr: got=%0d want=%0d", mem_wr_addr, wrn % 4); end
        wrn++;
      end
      if (mem_rd_en) begin
        total++; if (mem_rd_addr !== AW'(rdn % 4)) begin bad++; $display("[TB] FAIL wrap_rd_addr: got=%0d want=%0d", mem_rd_addr, rdn % 4); end
        rdn++;
      end
      if (in_valid && in_ready) src++;
      if (out_valid) begin
        total++; if (out_data !== items[outn]) begin bad++; $display("[TB] FAIL wrap_order: got=%h want=%h", out_data, items[outn]); end
        outn++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    total++; if (outn != 12) begin bad++; $display("[TB] FAIL wrap_timeout: got=%0d want=12", outn); end
  endtask

  task automatic test_random();
    logic [DW-1:0] q [$];
    logic [DW-1:0] exp_d;
    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_data = '0;
    do_reset();
    for (int i = 0; i < 2050; i++) begin
      // final 50 cycles drain whatever is left
      in_valid  = (i < 2000) ? ($urandom_range(0, 3) != 0) : 1'b0;
      out_ready = (i < 2000) ? ($urandom_range(0, 1) == 1) : 1'b1;
      in_data   = DW'($urandom);
      @(negedge clk);
      total++; if (mem_rd_en && mem_wr_en) begin bad++; $display("[TB] FAIL rnd_excl: got=rd1 wr1 want=not both"); end
      total++; if (int'(count) != q.size()) begin bad++; $display("[TB] FAIL rnd_count: got=%0d want=%0d", count, q.size()); end
      if (prev_hold) begin
        total++; if (out_valid !== 1'b1 || out_data !== prev_data) begin bad++; $display("[TB] FAIL rnd_stable: got=%b/%h want=1/%h", out_valid, out_data, prev_data); end
      end
      if (out_valid && out_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("[TB] FAIL rnd_dup: got=%h want=none", out_data);
        end else begin
          exp_d = q.pop_front();
          if (out_data !== exp_d) begin bad++; $display("[TB] FAIL rnd_data: got=%h want=%h", out_data, exp_d); end
        end
      end
      if (in_valid && in_ready) q.push_back(in_data);
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      @(posedge clk); #1;
    end
    total++; if (q.size() != 0) begin bad++; $display("[TB] FAIL rnd_loss: got=%0d want=0", q.size()); end
  endtask

  task automatic test_empty();
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b0 || mem_rd_en !== 1'b0) begin bad++; $display("[TB] FAIL empty: got=v%b rd%b want=v0 rd0", out_valid, mem_rd_en); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_random();
    test_empty();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
